// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush to bubbles, and saturating stall/bubble counters.
module pipe_stage_skid #(
  parameter int unsigned DATA_W              = 96,
  parameter int unsigned CTRL_W              = 16,
  parameter int unsigned CNT_W               = 16,
  parameter bit          CLEAR_DATA_ON_FLUSH = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_acc;
  logic              out_acc;

  assign in_acc    = in_valid & in_ready;
  assign out_acc   = out_valid & out_ready;
  // The state encoding is the entry count, so occupancy comes straight from the flop.
  assign occupancy = 2'(state);

  // Main slot drives out_*; skid slot only fills while main is stalled, and in_ready
  // is its registered inverse so backpressure never forms a combinational path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      out_data   <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      in_ready   <= 1'b1;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (!out_valid && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end

      if (flush) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
        out_ctrl  <= '0;
        skid_ctrl <= '0;
        in_ready  <= 1'b1;
        if (CLEAR_DATA_ON_FLUSH) begin
          out_data  <= '0;
          skid_data <= '0;
        end
      end else begin
        case (state)
          EMPTY: begin
            if (in_acc) begin
              state     <= ONE;
              out_valid <= 1'b1;
              out_ctrl  <= in_ctrl;
              out_data  <= in_data;
            end
          end
          ONE: begin
            if (in_acc && out_acc) begin
              out_ctrl <= in_ctrl;
              out_data <= in_data;
            end else if (in_acc) begin
              state     <= FULL;
              skid_ctrl <= in_ctrl;
              skid_data <= in_data;
              in_ready  <= 1'b0;
            end else if (out_acc) begin
              state     <= EMPTY;
              out_valid <= 1'b0;
              out_ctrl  <= '0;
            end
          end
          FULL: begin
            if (out_acc) begin
              state     <= ONE;
              out_ctrl  <= skid_ctrl;
              out_data  <= skid_data;
              skid_ctrl <= '0;
              in_ready  <= 1'b1;
            end
          end
          default: begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            in_ready  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: default instance plus a clear-on-flush,
// 4-bit-counter instance driven by the same stimulus.
module tb_pipe_stage_skid;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_ctrl;
  logic [95:0] in_data;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [15:0] out_ctrl;
  logic [95:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt, bubble_cnt;

  logic        c_in_ready, c_out_valid;
  logic [15:0] c_out_ctrl;
  logic [95:0] c_out_data;
  logic [1:0]  c_occupancy;
  logic [3:0]  c_stall_cnt, c_bubble_cnt;

  int total = 0;
  int bad   = 0;

  pipe_stage_skid dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_skid #(.CNT_W(4), .CLEAR_DATA_ON_FLUSH(1'b1)) dut_c (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_ctrl(c_out_ctrl), .out_data(c_out_data),
    .occupancy(c_occupancy), .stall_cnt(c_stall_cnt), .bubble_cnt(c_bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        iv;
    logic [15:0] ic;
    logic [95:0] id;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [15:0] ec;
    logic [95:0] ed;
    logic [95:0] edc;
    logic [1:0]  eo;
    logic        er;
    logic [15:0] es;
    logic [15:0] eb;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic iv, logic [15:0] ic, logic [95:0] id, logic ordy,
                              logic fl, logic ev, logic [15:0] ec, logic [95:0] ed,
                              logic [95:0] edc, logic [1:0] eo, logic er,
                              logic [15:0] es, logic [15:0] eb);
    vec_t v;
    v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.ec = ec; v.ed = ed; v.edc = edc; v.eo = eo; v.er = er;
    v.es = es; v.eb = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;

    //            iv ic      id       ordy fl  ev ec      ed       edc      eo er es bb
    tbl[0]  = mk(1, 16'h1,  96'h100, 1, 0,  1, 16'h1,  96'h100, 96'h100, 1, 1, 0, 1);
    tbl[1]  = mk(1, 16'h2,  96'h101, 1, 0,  1, 16'h2,  96'h101, 96'h101, 1, 1, 0, 1);
    tbl[2]  = mk(1, 16'h3,  96'h102, 1, 0,  1, 16'h3,  96'h102, 96'h102, 1, 1, 0, 1);
    tbl[3]  = mk(1, 16'h4,  96'h103, 1, 0,  1, 16'h4,  96'h103, 96'h103, 1, 1, 0, 1);
    tbl[4]  = mk(0, 16'h0,  96'h0,   1, 0,  0, 16'h0,  96'h103, 96'h103, 0, 1, 0, 1);
    tbl[5]  = mk(1, 16'h11, 96'h11,  0, 0,  1, 16'h11, 96'h11,  96'h11,  1, 1, 0, 2);
    tbl[6]  = mk(1, 16'h22, 96'h22,  0, 0,  1, 16'h11, 96'h11,  96'h11,  2, 0, 1, 2);
    tbl[7]  = mk(1, 16'h99, 96'h99,  0, 0,  1, 16'h11, 96'h11,  96'h11,  2, 0, 2, 2);
    tbl[8]  = mk(0, 16'h0,  96'h0,   1, 0,  1, 16'h22, 96'h22,  96'h22,  1, 1, 2, 2);
    tbl[9]  = mk(0, 16'h0,  96'h0,   1, 0,  0, 16'h0,  96'h22,  96'h22,  0, 1, 2, 2);
    tbl[10] = mk(1, 16'h11, 96'h11,  0, 0,  1, 16'h11, 96'h11,  96'h11,  1, 1, 2, 3);
    tbl[11] = mk(1, 16'h22, 96'h22,  0, 0,  1, 16'h11, 96'h11,  96'h11,  2, 0, 3, 3);
    tbl[12] = mk(1, 16'h33, 96'h33,  0, 1,  0, 16'h0,  96'h11,  96'h0,   0, 1, 4, 3);
    tbl[13] = mk(0, 16'h0,  96'h0,   1, 0,  0, 16'h0,  96'h11,  96'h0,   0, 1, 4, 4);
    tbl[14] = mk(1, 16'h5,  96'h5,   1, 0,  1, 16'h5,  96'h5,   96'h5,   1, 1, 4, 5);
    tbl[15] = mk(1, 16'h6,  96'h6,   1, 1,  0, 16'h0,  96'h5,   96'h0,   0, 1, 4, 5);
    tbl[16] = mk(0, 16'h0,  96'h0,   1, 0,  0, 16'h0,  96'h5,   96'h0,   0, 1, 4, 6);

    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", 128'(out_valid), 128'(0));
    check("rst out_ctrl",  128'(out_ctrl),  128'(0));
    check("rst out_data",  128'(out_data),  128'(0));
    check("rst in_ready",  128'(in_ready),  128'(1));
    check("rst occupancy", 128'(occupancy), 128'(0));
    check("rst stall_cnt", 128'(stall_cnt), 128'(0));
    check("rst bubble",    128'(bubble_cnt), 128'(0));
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      in_valid  = tbl[i].iv;
      in_ctrl   = tbl[i].ic;
      in_data   = tbl[i].id;
      out_ready = tbl[i].ordy;
      flush     = tbl[i].fl;
      step();
      check($sformatf("row%0d out_valid", i), 128'(out_valid), 128'(tbl[i].ev));
      check($sformatf("row%0d out_ctrl", i),  128'(out_ctrl),  128'(tbl[i].ec));
      check($sformatf("row%0d out_data", i),  128'(out_data),  128'(tbl[i].ed));
      check($sformatf("row%0d occupancy", i), 128'(occupancy), 128'(tbl[i].eo));
      check($sformatf("row%0d in_ready", i),  128'(in_ready),  128'(tbl[i].er));
      check($sformatf("row%0d stall_cnt", i), 128'(stall_cnt), 128'(tbl[i].es));
      check($sformatf("row%0d bubble", i),    128'(bubble_cnt), 128'(tbl[i].eb));
      check($sformatf("row%0d clr out_ctrl", i), 128'(c_out_ctrl), 128'(tbl[i].ec));
      check($sformatf("row%0d clr out_data", i), 128'(c_out_data), 128'(tbl[i].edc));
    end
    flush = 1'b0;

    // Idle for 20 cycles: 4-bit bubble counter pins at 15, 16-bit one keeps counting.
    in_valid  = 1'b0;
    in_ctrl   = 16'hdead;
    in_data   = 96'hbeef;
    out_ready = 1'b1;
    repeat (20) step();
    check("sat clr bubble", 128'(c_bubble_cnt), 128'(15));
    check("sat def bubble", 128'(bubble_cnt), 128'(26));
    check("idle out_ctrl",  128'(out_ctrl), 128'(0));
    repeat (3) step();
    check("sat clr hold",   128'(c_bubble_cnt), 128'(15));

    // Fill to FULL, then assert reset mid-cycle with no clock edge.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'h41; in_data = 96'h41;
    step();
    in_ctrl   = 16'h42; in_data = 96'h42;
    step();
    in_valid  = 1'b0;
    step();
    check("full occupancy", 128'(occupancy), 128'(2));
    check("full stall_cnt", 128'(stall_cnt), 128'(6));
    check("full in_ready",  128'(in_ready), 128'(0));
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst out_valid", 128'(out_valid), 128'(0));
    check("arst occupancy", 128'(occupancy), 128'(0));
    check("arst stall_cnt", 128'(stall_cnt), 128'(0));
    check("arst bubble",    128'(bubble_cnt), 128'(0));
    check("arst in_ready",  128'(in_ready), 128'(1));
    check("arst out_ctrl",  128'(out_ctrl), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
